btn_event_decoder: RTL and testbench

//   Sits directly downstream of the 3-flop button synchronizer in the alarm clock design; consumes its btn_out.

---
 rtl/btn_event_decoder.sv | 149 ++++++++++++++
 tb/tb_btn_event_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// Debounces a synchronized button level and classifies it into one-cycle
// press/release/long/repeat events using a single shared counter.
module btn_event_decoder #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LONG_CYCLES     = 100_000_000,
   parameter int REPEAT_CYCLES   = 20_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_sync,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic long_held
);

   localparam int MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ?
                           DEBOUNCE_CYCLES : LONG_CYCLES;
   localparam int MAX_C  = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
   localparam int CW     = $clog2(MAX_C) + 1;

   localparam logic [CW-1:0] DB_TC   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] RPT_TC  = CW'(REPEAT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      DB_PRESS,
      PRESSED,
      LONG_HELD,
      DB_RELEASE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          long_held_q, long_held_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          long_q, long_d;
   logic          repeat_q, repeat_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      level_d     = level_q;
      long_held_d = long_held_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      repeat_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (btn_sync) begin
               state_d = DB_PRESS;
               cnt_d   = '0;
            end
         end
         DB_PRESS: begin
            if (!btn_sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_TC) begin
               state_d = PRESSED;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESSED: begin
            if (!btn_sync) begin
               state_d = DB_RELEASE;
               cnt_d   = '0;
            end else if (cnt_q == LONG_TC) begin
               state_d     = LONG_HELD;
               cnt_d       = '0;
               long_d      = 1'b1;
               long_held_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         LONG_HELD: begin
            if (!btn_sync) begin
               state_d = DB_RELEASE;
               cnt_d   = '0;
            end else if (cnt_q == RPT_TC) begin
               cnt_d    = '0;
               repeat_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DB_RELEASE: begin
            // a bounce back to 1 resumes the hold with a fresh count
            if (btn_sync) begin
               state_d = long_held_q ? LONG_HELD : PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == DB_TC) begin
               state_d     = IDLE;
               cnt_d       = '0;
               level_d     = 1'b0;
               long_held_d = 1'b0;
               release_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         long_held_q <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         repeat_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         long_held_q <= long_held_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
         repeat_q    <= repeat_d;
      end
   end

   assign btn_level     = level_q;
   assign long_held     = long_held_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: directed scenarios plus random bursts,
// all checked cycle by cycle against a run-length reference model.
module tb_btn_event_decoder;

   localparam int D = 4;
   localparam int L = 16;
   localparam int R = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_sync = 1'b0;
   logic btn_level, press_pulse, release_pulse;
   logic long_pulse, repeat_pulse, long_held;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   bit       m_level = 1'b0;
   bit       m_long  = 1'b0;
   int       m_run   = 0;
   int       m_hold  = 0;
   logic [5:0] exp_v = '0;
   logic [5:0] obs_v;

   assign obs_v = {btn_level, long_held, press_pulse,
                   release_pulse, long_pulse, repeat_pulse};

   btn_event_decoder #(
      .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES    (L),
      .REPEAT_CYCLES  (R)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_sync     (btn_sync),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .long_held    (long_held)
   );

   always #5 clk = ~clk;

   // Reference: an edge is accepted after D+1 consecutive samples at the
   // new level; hold time counts samples since press or bounce-back.
   task automatic model_update(input logic b, input logic r);
      bit pr = 0, rl = 0, lg = 0, rp = 0;
      if (r) begin
         m_level = 0; m_long = 0; m_run = 0; m_hold = 0;
      end else if (b != m_level) begin
         m_run++;
         if (m_run == D + 1) begin
            m_level = b;
            m_run   = 0;
            m_hold  = 0;
            if (b) pr = 1;
            else begin rl = 1; m_long = 0; end
         end
      end else if (m_run > 0) begin
         m_run  = 0;
         m_hold = 0;
      end else if (m_level) begin
         m_hold++;
         if (!m_long && m_hold == L) begin
            lg = 1; m_long = 1; m_hold = 0;
         end else if (m_long && m_hold == R) begin
            rp = 1; m_hold = 0;
         end
      end
      exp_v = {m_level, m_long, pr, rl, lg, rp};
   endtask

   task automatic step(input logic b, input logic r);
      btn_sync = b;
      rst      = r;
      @(posedge clk);
      model_update(b, r);
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1);
         n_tests++;
         if (obs_v !== 6'b0) begin
            n_fail++;
            $display("FAIL reset cyc %0d: got %b want %b", cyc, obs_v, 6'b0);
         end
      end
      step(1'b0, 1'b0);
   endtask

   task automatic test_glitch();
      int pulses = 0;
      for (int i = 0; i < 9; i++) begin
         step(i < 3, 1'b0);
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL glitch cyc %0d: got %b want %b", cyc, obs_v, exp_v);
         end
         pulses += int'(press_pulse) + int'(release_pulse) + int'(btn_level);
      end
      n_tests++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL glitch_quiet: got %0d activity want 0", pulses);
      end
   endtask

   task automatic test_short_press();
      int press_at = -1, rel_at = -1, longs = 0;
      for (int i = 0; i < 20; i++) begin
         step(i < 10, 1'b0);
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL short_press cyc %0d: got %b want %b", cyc, obs_v, exp_v);
         end
         if (press_pulse) press_at = i;
         if (release_pulse) rel_at = i;
         if (long_pulse) longs++;
      end
      n_tests++;
      if (press_at != 4 || rel_at != 14 || longs != 0) begin
         n_fail++;
         $display("FAIL short_press_timing: got p%0d r%0d l%0d want p4 r14 l0",
                  press_at, rel_at, longs);
      end
   endtask

   task automatic test_long_hold();
      int long_at = -1, rel_at = -1;
      int rpt[$];
      for (int i = 0; i < 54; i++) begin
         step(i < 40, 1'b0);
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL long_hold cyc %0d: got %b want %b", cyc, obs_v, exp_v);
         end
         if (long_pulse) long_at = i;
         if (repeat_pulse) rpt.push_back(i);
         if (release_pulse) rel_at = i;
      end
      n_tests++;
      if (long_at != 20 || rel_at != 44 || rpt.size() != 2 ||
          rpt[0] != 28 || rpt[1] != 36 || long_held !== 1'b0) begin
         n_fail++;
         $display("FAIL long_hold_timing: got l%0d r%0d n%0d held%b want l20 r44 n2 held0",
                  long_at, rel_at, rpt.size(), long_held);
      end
   endtask

   task automatic test_release_glitch();
      int long_at = -1, rel_early = 0, lvl_drop = 0;
      for (int i = 0; i < 44; i++) begin
         step(!(i == 6 || i == 7 || i >= 34), 1'b0);
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL release_glitch cyc %0d: got %b want %b", cyc, obs_v, exp_v);
         end
         if (long_pulse) long_at = i;
         if (i < 34 && release_pulse) rel_early++;
         if (i >= 4 && i < 34 && !btn_level) lvl_drop++;
      end
      n_tests++;
      if (long_at != 24 || rel_early != 0 || lvl_drop != 0) begin
         n_fail++;
         $display("FAIL release_glitch_timing: got l%0d r%0d d%0d want l24 r0 d0",
                  long_at, rel_early, lvl_drop);
      end
   endtask

   task automatic test_reset_mid();
      int press_at = -1;
      for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      n_tests++;
      if (obs_v !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_mid_clear: got %b want %b", obs_v, 6'b0);
      end
      for (int i = 0; i < 16; i++) begin
         step(i < 8, 1'b0);
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid cyc %0d: got %b want %b", cyc, obs_v, exp_v);
         end
         if (press_pulse) press_at = i;
      end
      n_tests++;
      if (press_at != 4) begin
         n_fail++;
         $display("FAIL reset_mid_repress: got %0d want 4", press_at);
      end
   endtask

   task automatic test_reset_same_cycle();
      int press_at = -1;
      for (int i = 0; i < 18; i++) begin
         step(i < 9, i == 0);
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_same cyc %0d: got %b want %b", cyc, obs_v, exp_v);
         end
         if (press_pulse) press_at = i;
      end
      n_tests++;
      if (press_at != 5) begin
         n_fail++;
         $display("FAIL reset_same_timing: got %0d want 5", press_at);
      end
   endtask

   task automatic test_random();
      for (int burst = 0; burst < 150; burst++) begin
         int hi = $urandom_range(1, 50);
         int lo = $urandom_range(1, 12);
         for (int i = 0; i < hi + lo; i++) begin
            step(i < hi, $urandom_range(0, 199) == 0);
            n_tests++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("FAIL random cyc %0d: got %b want %b", cyc, obs_v, exp_v);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_short_press();
      test_long_hold();
      test_release_glitch();
      test_reset_mid();
      test_reset_same_cycle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
